// File: rtl/fsm_ctrl_pkg.sv
// fsm_ctrl_pkg
//   Shared definitions for the flow-control supervisor FSM. The package holds
//   the state encoding, the state width and a ceil-log2 helper that sizes the
//   idle dwell counter.
package fsm_ctrl_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    // Returns ceil(log2(v)), with a minimum of 1 so that a counter is never zero-width.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fsm_ctrl_cfg_check.sv
// fsm_ctrl_cfg_check
//   Combinational threshold validator. For each FIFO it flags a configuration
//   where the almost-empty threshold is not strictly below the almost-full
//   threshold.
//   Ports:
//     ae_i        packed almost-empty thresholds, FIFO i at [i*TH_W +: TH_W]
//     af_i        packed almost-full thresholds, same packing
//     fail_o      per-FIFO fail flag (ae >= af)
//     any_fail_o  OR of fail_o
module fsm_ctrl_cfg_check
    import fsm_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FIFO = 5,
    parameter int unsigned TH_W     = 4
) (
    input  logic [NUM_FIFO*TH_W-1:0] ae_i,
    input  logic [NUM_FIFO*TH_W-1:0] af_i,
    output logic [NUM_FIFO-1:0]      fail_o,
    output logic                     any_fail_o
);

    always_comb begin
        fail_o = '0;
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            fail_o[i] = (ae_i[i*TH_W +: TH_W] >= af_i[i*TH_W +: TH_W]);
        end
    end

    assign any_fail_o = |fail_o;

endmodule

// File: rtl/fsm_ctrl_multi.sv
// fsm_ctrl_multi
//   Supervisor FSM for NUM_FIFO FIFOs. It captures and validates per-FIFO
//   thresholds during INIT, tracks IDLE/ACTIVE with an idle dwell of IDLE_CYC
//   all-empty cycles, and latches FIFO error sources in ERROR until init or
//   reset.
//   Ports:
//     clk, reset_L                  clock, asynchronous active-low reset
//     init                          level; forces INIT and threshold capture
//     umbral_ae_in / umbral_af_in   packed thresholds, FIFO i at [i*TH_W +: TH_W]
//     fifo_error, fifo_empty        per-FIFO status flags
//     umbral_ae_out / umbral_af_out registered thresholds
//     idle_out, active_out, error_out  registered state indications
//     error_src                     sticky OR of fifo_error seen in ERROR
//     cfg_err                       threshold validation failed
//     state_out                     current state encoding
module fsm_ctrl_multi
    import fsm_ctrl_pkg::*;
#(
    parameter int unsigned NUM_FIFO = 5,
    parameter int unsigned TH_W     = 4,
    parameter int unsigned IDLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     init,
    input  logic [NUM_FIFO*TH_W-1:0] umbral_ae_in,
    input  logic [NUM_FIFO*TH_W-1:0] umbral_af_in,
    input  logic [NUM_FIFO-1:0]      fifo_error,
    input  logic [NUM_FIFO-1:0]      fifo_empty,
    output logic [NUM_FIFO*TH_W-1:0] umbral_ae_out,
    output logic [NUM_FIFO*TH_W-1:0] umbral_af_out,
    output logic                     idle_out,
    output logic                     active_out,
    output logic                     error_out,
    output logic [NUM_FIFO-1:0]      error_src,
    output logic                     cfg_err,
    output logic [STATE_W-1:0]       state_out
);

    localparam int unsigned CNT_W = clog2(IDLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_CYC);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [NUM_FIFO-1:0]        error_src_q, error_src_d;
    logic                       cfg_err_q, cfg_err_d;
    logic [NUM_FIFO*TH_W-1:0]   ae_q, af_q;
    logic                       idle_q, active_q, error_q;
    logic                       any_error, all_empty;
    logic                       cfg_fail;
    // Per-FIFO detail is not consumed here; kept at the boundary for debug probing.
    logic [NUM_FIFO-1:0]        cfg_fail_vec_unused;

    // Validation runs on the registered thresholds, i.e. the values captured
    // on the last edge that still had the FSM heading into INIT.
    fsm_ctrl_cfg_check #(
        .NUM_FIFO (NUM_FIFO),
        .TH_W     (TH_W)
    ) u_cfg_check (
        .ae_i       (ae_q),
        .af_i       (af_q),
        .fail_o     (cfg_fail_vec_unused),
        .any_fail_o (cfg_fail)
    );

    assign any_error = |fifo_error;
    assign all_empty = (fifo_empty == '1);
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        error_src_d = error_src_q;
        cfg_err_d   = cfg_err_q;

        if (init) begin
            state_d     = ST_INIT;
            error_src_d = '0;
            cfg_err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_RESET: state_d = ST_INIT;
                ST_INIT: begin
                    if (cfg_fail) begin
                        state_d   = ST_ERROR;
                        cfg_err_d = 1'b1;
                    end else if (any_error) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (any_error) begin
                        state_d = ST_ERROR;
                    end else if (!all_empty) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (any_error) begin
                        state_d = ST_ERROR;
                    end else if (all_empty) begin
                        if (cnt_inc == CNT_MAX) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_RESET;
            endcase

            // Error sources accumulate on every edge that lands in ERROR,
            // including the entry edge.
            if (state_d == ST_ERROR) begin
                error_src_d = error_src_q | fifo_error;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            error_src_q <= '0;
            cfg_err_q   <= 1'b0;
            ae_q        <= '0;
            af_q        <= '0;
            idle_q      <= 1'b0;
            active_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            error_src_q <= error_src_d;
            cfg_err_q   <= cfg_err_d;
            if (state_d == ST_INIT) begin
                ae_q <= umbral_ae_in;
                af_q <= umbral_af_in;
            end
            idle_q   <= (state_d == ST_IDLE);
            active_q <= (state_d == ST_ACTIVE);
            error_q  <= (state_d == ST_ERROR);
        end
    end

    assign umbral_ae_out = ae_q;
    assign umbral_af_out = af_q;
    assign idle_out      = idle_q;
    assign active_out    = active_q;
    assign error_out     = error_q;
    assign error_src     = error_src_q;
    assign cfg_err       = cfg_err_q;
    assign state_out     = state_q;

endmodule

// File: tb/tb_fsm_ctrl_multi.sv
module tb_fsm_ctrl_multi;

    localparam int unsigned NUM_FIFO = 5;
    localparam int unsigned TH_W     = 4;
    localparam int unsigned IDLE_CYC = 4;

    logic                     clk = 1'b0;
    logic                     reset_L;
    logic                     init;
    logic [NUM_FIFO*TH_W-1:0] umbral_ae_in, umbral_af_in;
    logic [NUM_FIFO-1:0]      fifo_error, fifo_empty;
    logic [NUM_FIFO*TH_W-1:0] umbral_ae_out, umbral_af_out;
    logic                     idle_out, active_out, error_out, cfg_err;
    logic [NUM_FIFO-1:0]      error_src;
    logic [2:0]               state_out;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    fsm_ctrl_multi #(
        .NUM_FIFO (NUM_FIFO),
        .TH_W     (TH_W),
        .IDLE_CYC (IDLE_CYC)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .init          (init),
        .umbral_ae_in  (umbral_ae_in),
        .umbral_af_in  (umbral_af_in),
        .fifo_error    (fifo_error),
        .fifo_empty    (fifo_empty),
        .umbral_ae_out (umbral_ae_out),
        .umbral_af_out (umbral_af_out),
        .idle_out      (idle_out),
        .active_out    (active_out),
        .error_out     (error_out),
        .error_src     (error_src),
        .cfg_err       (cfg_err),
        .state_out     (state_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected state code and the one-hot indications that go with it.
    task automatic check_state(input string tag, input logic [2:0] st);
        check({tag, ".state"},  32'(state_out),  32'(st));
        check({tag, ".idle"},   32'(idle_out),   32'(st == 3'd2));
        check({tag, ".active"}, 32'(active_out), 32'(st == 3'd3));
        check({tag, ".error"},  32'(error_out),  32'(st == 3'd4));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_L      = 1'b0;
        init         = 1'b1;
        umbral_ae_in = 20'h44444;
        umbral_af_in = 20'hCCCCC;
        fifo_error   = '0;
        fifo_empty   = 5'b11111;
        tick();
        tick();
        check_state("rst", 3'd0);
        check("rst.ae", 32'(umbral_ae_out), 32'h0);
        check("rst.src", 32'(error_src), 32'h0);

        // Release, RESET -> INIT, thresholds captured while init held
        reset_L = 1'b1;
        tick();
        check_state("init0", 3'd1);
        tick();
        check_state("init1", 3'd1);
        init = 1'b0;
        tick();
        check_state("cfg_ok", 3'd2);
        check("cfg_ok.ae", 32'(umbral_ae_out), 32'h44444);
        check("cfg_ok.af", 32'(umbral_af_out), 32'hCCCCC);
        check("cfg_ok.cfg", 32'(cfg_err), 32'h0);

        // Activity, then full dwell of IDLE_CYC all-empty edges
        fifo_empty = 5'b11110;
        tick();
        check_state("act", 3'd3);
        fifo_empty = 5'b11111;
        repeat (3) tick();
        check_state("dwell3", 3'd3);
        tick();
        check_state("dwell4", 3'd2);

        // Dwell broken at the 3rd cycle restarts the count
        fifo_empty = 5'b11110;
        tick();
        fifo_empty = 5'b11111;
        repeat (2) tick();
        fifo_empty = 5'b01111;
        tick();
        check_state("brk", 3'd3);
        fifo_empty = 5'b11111;
        repeat (3) tick();
        check_state("brk.d3", 3'd3);
        tick();
        check_state("brk.d4", 3'd2);

        // Error latch from ACTIVE
        fifo_empty = 5'b11110;
        tick();
        fifo_error = 5'b00100;
        tick();
        check_state("err", 3'd4);
        check("err.src", 32'(error_src), 32'h04);
        check("err.cfg", 32'(cfg_err), 32'h0);
        fifo_error = '0;
        tick();
        check_state("err.hold", 3'd4);
        check("err.hold.src", 32'(error_src), 32'h04);
        fifo_error = 5'b00001;
        tick();
        check("err.acc.src", 32'(error_src), 32'h05);
        fifo_error = '0;

        // init clears everything
        init = 1'b1;
        umbral_ae_in = 20'h44C44;
        umbral_af_in = 20'hCC4CC;
        tick();
        check_state("reinit", 3'd1);
        check("reinit.src", 32'(error_src), 32'h0);
        check("reinit.cfg", 32'(cfg_err), 32'h0);

        // Bad config: FIFO 2 ae=12 > af=4
        init = 1'b0;
        tick();
        check_state("bad", 3'd4);
        check("bad.cfg", 32'(cfg_err), 32'h1);
        check("bad.src", 32'(error_src), 32'h0);
        check("bad.ae", 32'(umbral_ae_out), 32'h44C44);

        // Bad config: FIFO 2 ae=af=7
        init = 1'b1;
        umbral_ae_in = 20'h44744;
        umbral_af_in = 20'hCC7CC;
        tick();
        check("eq.init.cfg", 32'(cfg_err), 32'h0);
        init = 1'b0;
        tick();
        check_state("eq", 3'd4);
        check("eq.cfg", 32'(cfg_err), 32'h1);

        // Boundary pass: ae=6 < af=7
        init = 1'b1;
        umbral_ae_in = 20'h44644;
        tick();
        init = 1'b0;
        tick();
        check_state("lt", 3'd2);
        check("lt.cfg", 32'(cfg_err), 32'h0);

        // Error wins over non-empty; thresholds unaffected by new inputs
        fifo_error   = 5'b10000;
        fifo_empty   = 5'b00000;
        umbral_ae_in = 20'h11111;
        umbral_af_in = 20'h22222;
        tick();
        check_state("simul", 3'd4);
        check("simul.src", 32'(error_src), 32'h10);
        check("simul.ae", 32'(umbral_ae_out), 32'h44644);
        check("simul.af", 32'(umbral_af_out), 32'hCC7CC);

        // init wins over fifo_error
        init         = 1'b1;
        fifo_error   = 5'b01000;
        fifo_empty   = 5'b11111;
        umbral_ae_in = 20'h44444;
        umbral_af_in = 20'hCCCCC;
        tick();
        check_state("init_pri", 3'd1);
        check("init_pri.src", 32'(error_src), 32'h0);

        // Valid thresholds but FIFO error on INIT exit
        init       = 1'b0;
        fifo_error = 5'b00010;
        tick();
        check_state("init_err", 3'd4);
        check("init_err.cfg", 32'(cfg_err), 32'h0);
        check("init_err.src", 32'(error_src), 32'h02);
        fifo_error = '0;

        // Asynchronous reset mid-cycle
        #2;
        reset_L = 1'b0;
        #1;
        check_state("arst", 3'd0);
        check("arst.src", 32'(error_src), 32'h0);
        check("arst.ae", 32'(umbral_ae_out), 32'h0);
        check("arst.cfg", 32'(cfg_err), 32'h0);
        #3;
        reset_L = 1'b1;
        tick();
        check_state("arst.rel", 3'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
